// File: rtl/wb_stage_if.sv
// Write-back stage bundle: memory-stage inputs, W-register control and
// register-file / status outputs. clock and reset stay outside as plain ports.
interface wb_stage_if;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;
    logic [63:0] m_valE;
    logic [63:0] m_valM;
    logic        W_stall;
    logic        W_bubble;

    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [2:0]  Stat;
    logic        halted;
    logic [31:0] retired;

    // Pipeline side driving the stage
    modport master (
        output m_stat, m_icode, m_dstE, m_dstM, m_valE, m_valM, W_stall, W_bubble,
        input  dstE, dstM, valE, valM, W_stat, W_icode, Stat, halted, retired
    );

    // The write-back stage itself
    modport slave (
        input  m_stat, m_icode, m_dstE, m_dstM, m_valE, m_valM, W_stall, W_bubble,
        output dstE, dstM, valE, valM, W_stat, W_icode, Stat, halted, retired
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: W pipeline register, register-file write gating,
// sticky processor status with a RUN/HALT FSM, and a retired-instruction counter.
module wb_stage (
    input  logic        clock,
    input  logic        reset,
    wb_stage_if.slave   wb
);
    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} wb_state_e;
    typedef enum logic [1:0] {SEL_HOLD = 2'd0, SEL_BUBBLE = 2'd1, SEL_LOAD = 2'd2} w_sel_e;

    wb_state_e   state_r;
    wb_state_e   state_next_s;
    w_sel_e      w_sel_s;

    logic [2:0]  w_stat_r;
    logic [3:0]  w_icode_r;
    logic [3:0]  w_dst_e_r;
    logic [3:0]  w_dst_m_r;
    logic [63:0] w_val_e_r;
    logic [63:0] w_val_m_r;
    logic        w_valid_r;

    logic [2:0]  stat_r;
    logic [31:0] retired_r;

    logic        halt_trig_s;
    logic        retire_s;
    logic        halted_s;
    logic        write_en_s;
    logic [3:0]  dst_e_s;
    logic [3:0]  dst_m_s;

    // Event detection on the instruction currently sitting in W
    always_comb begin
        halt_trig_s = 1'b0;
        retire_s    = 1'b0;
        if (state_r == ST_RUN) begin
            halt_trig_s = w_valid_r && (w_stat_r != STAT_AOK);
            retire_s    = w_valid_r && (w_stat_r == STAT_AOK) && !wb.W_stall;
        end else begin
            halt_trig_s = 1'b0;
            retire_s    = 1'b0;
        end
    end

    // W load selection: a halted machine or a stall freezes W, stall beats bubble
    always_comb begin
        w_sel_s = SEL_LOAD;
        if (state_r == ST_HALT) begin
            w_sel_s = SEL_HOLD;
        end else if (wb.W_stall) begin
            w_sel_s = SEL_HOLD;
        end else if (wb.W_bubble) begin
            w_sel_s = SEL_BUBBLE;
        end else begin
            w_sel_s = SEL_LOAD;
        end
    end

    // W pipeline register
    always_ff @(posedge clock) begin
        if (reset) begin
            w_stat_r  <= STAT_AOK;
            w_icode_r <= ICODE_NOP;
            w_dst_e_r <= REG_NONE;
            w_dst_m_r <= REG_NONE;
            w_val_e_r <= 64'd0;
            w_val_m_r <= 64'd0;
            w_valid_r <= 1'b0;
        end else begin
            case (w_sel_s)
                SEL_LOAD: begin
                    w_stat_r  <= wb.m_stat;
                    w_icode_r <= wb.m_icode;
                    w_dst_e_r <= wb.m_dstE;
                    w_dst_m_r <= wb.m_dstM;
                    w_val_e_r <= wb.m_valE;
                    w_val_m_r <= wb.m_valM;
                    w_valid_r <= 1'b1;
                end
                SEL_BUBBLE: begin
                    w_stat_r  <= STAT_AOK;
                    w_icode_r <= ICODE_NOP;
                    w_dst_e_r <= REG_NONE;
                    w_dst_m_r <= REG_NONE;
                    w_val_e_r <= 64'd0;
                    w_val_m_r <= 64'd0;
                    w_valid_r <= 1'b0;
                end
                default: begin
                    // hold: W keeps its contents
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: a non-AOK instruction in W halts the machine for good
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt_trig_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: state_next_s = ST_HALT;
            default: state_next_s = ST_RUN;
        endcase
    end

    // FSM outputs: halted flag and register-file write gating
    always_comb begin
        halted_s   = (state_r == ST_HALT);
        write_en_s = (state_r == ST_RUN) && (w_stat_r == STAT_AOK);
        if (write_en_s) begin
            dst_e_s = w_dst_e_r;
            dst_m_s = w_dst_m_r;
        end else begin
            dst_e_s = REG_NONE;
            dst_m_s = REG_NONE;
        end
    end

    // Sticky status: reads AOK while running, captures the faulting status on halt
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_r <= STAT_AOK;
        end else if (halt_trig_s) begin
            stat_r <= w_stat_r;
        end else begin
            stat_r <= stat_r;
        end
    end

    // Retired counter: counts each AOK instruction once, as it leaves W; wraps silently
    always_ff @(posedge clock) begin
        if (reset) begin
            retired_r <= 32'd0;
        end else if (retire_s) begin
            retired_r <= retired_r + 32'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign wb.dstE    = dst_e_s;
    assign wb.dstM    = dst_m_s;
    assign wb.valE    = w_val_e_r;
    assign wb.valM    = w_val_m_r;
    assign wb.W_stat  = w_stat_r;
    assign wb.W_icode = w_icode_r;
    assign wb.Stat    = stat_r;
    assign wb.halted  = halted_s;
    assign wb.retired = retired_r;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the write-back stage.
module tb_wb_stage;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    wb_stage_if ifc ();

    wb_stage dut (
        .clock (clock),
        .reset (reset),
        .wb    (ifc)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [63:0] vale;
        logic [63:0] valm;
        bit          valid;
    } w_t;

    w_t          mw;
    bit          m_halted;
    logic [2:0]  m_stat;
    logic [31:0] m_ret;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic w_t bubble_w();
        w_t b;
        b.stat = 3'd1; b.icode = 4'h1; b.dste = 4'hF; b.dstm = 4'hF;
        b.vale = 64'd0; b.valm = 64'd0; b.valid = 1'b0;
        return b;
    endfunction

    // Reference behaviour for one clock edge, using the inputs present at that edge
    task automatic model_edge();
        if (reset) begin
            mw       = bubble_w();
            m_halted = 1'b0;
            m_stat   = 3'd1;
            m_ret    = 32'd0;
        end else if (!m_halted) begin
            bit aok;
            aok = (mw.stat == 3'd1);
            if (mw.valid && aok && !ifc.W_stall) m_ret = m_ret + 32'd1;
            if (mw.valid && !aok) begin
                m_halted = 1'b1;
                m_stat   = mw.stat;
            end
            if (ifc.W_stall) begin
                // held
            end else if (ifc.W_bubble) begin
                mw = bubble_w();
            end else begin
                mw.stat  = ifc.m_stat;  mw.icode = ifc.m_icode;
                mw.dste  = ifc.m_dstE;  mw.dstm  = ifc.m_dstM;
                mw.vale  = ifc.m_valE;  mw.valm  = ifc.m_valM;
                mw.valid = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        bit wr;
        wr = !m_halted && (mw.stat == 3'd1);
        check_eq("dstE",    ifc.dstE,    wr ? mw.dste : 4'hF);
        check_eq("dstM",    ifc.dstM,    wr ? mw.dstm : 4'hF);
        check_eq("valE",    ifc.valE,    mw.vale);
        check_eq("valM",    ifc.valM,    mw.valm);
        check_eq("W_stat",  ifc.W_stat,  mw.stat);
        check_eq("W_icode", ifc.W_icode, mw.icode);
        check_eq("Stat",    ifc.Stat,    m_halted ? m_stat : 3'd1);
        check_eq("halted",  ifc.halted,  m_halted);
        check_eq("retired", ifc.retired, m_ret);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                         input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm,
                         input logic sl, input logic bb);
        ifc.m_stat = st; ifc.m_icode = ic; ifc.m_dstE = de; ifc.m_dstM = dm;
        ifc.m_valE = ve; ifc.m_valM = vm; ifc.W_stall = sl; ifc.W_bubble = bb;
    endtask

    initial begin
        int halt_age;
        mw = bubble_w(); m_halted = 1'b0; m_stat = 3'd1; m_ret = 32'd0;

        // Reset state
        reset = 1'b1;
        drive(3'd1, 4'h6, 4'h2, 4'h3, 64'h77, 64'h88, 1'b1, 1'b1);
        @(negedge clock);
        step();
        step();
        check_eq("rst_dstE",    ifc.dstE,    4'hF);
        check_eq("rst_dstM",    ifc.dstM,    4'hF);
        check_eq("rst_valE",    ifc.valE,    64'd0);
        check_eq("rst_W_stat",  ifc.W_stat,  3'd1);
        check_eq("rst_W_icode", ifc.W_icode, 4'h1);
        check_eq("rst_Stat",    ifc.Stat,    3'd1);
        check_eq("rst_halted",  ifc.halted,  1'b0);
        check_eq("rst_retired", ifc.retired, 32'd0);
        reset = 1'b0;

        // Normal load, one-cycle latency, retire on the following edge
        drive(3'd1, 4'h6, 4'h3, 4'hF, 64'h1234, 64'h0, 1'b0, 1'b0);
        step();
        check_eq("load_dstE",    ifc.dstE,    4'h3);
        check_eq("load_valE",    ifc.valE,    64'h1234);
        check_eq("load_dstM",    ifc.dstM,    4'hF);
        check_eq("load_retired", ifc.retired, 32'd0);
        drive(3'd1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b1);
        step();
        check_eq("load_retired1", ifc.retired, 32'd1);

        // Stall for three cycles, then stall+bubble, then release
        drive(3'd1, 4'h6, 4'h5, 4'h7, 64'hAA, 64'hBB, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(3'd1, 4'h2, 4'h9, 4'h8, 64'($urandom), 64'($urandom), 1'b1, 1'b0);
            step();
            check_eq("stall_dstE", ifc.dstE, 4'h5);
            check_eq("stall_retired", ifc.retired, 32'd1);
        end
        drive(3'd1, 4'h2, 4'h9, 4'h8, 64'h5, 64'h6, 1'b1, 1'b1);
        step();
        check_eq("stallbub_dstE", ifc.dstE, 4'h5);
        check_eq("stallbub_valE", ifc.valE, 64'hAA);
        drive(3'd1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b1);
        step();
        check_eq("release_retired", ifc.retired, 32'd2);

        // Halt instruction
        drive(3'd2, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);
        step();
        check_eq("hlt_dstE", ifc.dstE, 4'hF);
        check_eq("hlt_halted_early", ifc.halted, 1'b0);
        drive(3'd1, 4'h2, 4'h1, 4'h2, 64'h55, 64'h66, 1'b0, 1'b0);
        step();
        check_eq("hlt_halted", ifc.halted, 1'b1);
        check_eq("hlt_Stat", ifc.Stat, 3'd2);
        check_eq("hlt_dstE_gated", ifc.dstE, 4'hF);
        for (int i = 0; i < 3; i++) begin
            drive(3'd1, 4'h2, 4'h3, 4'h4, 64'($urandom), 64'($urandom), 1'b0, 1'b0);
            step();
            check_eq("hlt_retired", ifc.retired, 32'd2);
        end

        // Memory error: no write to register 0, then reset recovers
        reset = 1'b1; step(); reset = 1'b0;
        drive(3'd3, 4'h5, 4'hF, 4'h0, 64'h0, 64'h99, 1'b0, 1'b0);
        step();
        check_eq("adr_dstM", ifc.dstM, 4'hF);
        drive(3'd1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b1);
        step();
        check_eq("adr_Stat", ifc.Stat, 3'd3);
        check_eq("adr_halted", ifc.halted, 1'b1);
        reset = 1'b1; drive(3'd1, 4'h1, 4'h1, 4'h1, 64'h1, 64'h1, 1'b1, 1'b1);
        step();
        reset = 1'b0;
        check_eq("adr_rst_Stat", ifc.Stat, 3'd1);
        check_eq("adr_rst_halted", ifc.halted, 1'b0);
        check_eq("adr_rst_retired", ifc.retired, 32'd0);

        // Collision and counter wrap
        drive(3'd1, 4'hB, 4'h4, 4'h4, 64'h111, 64'h222, 1'b0, 1'b0);
        step();
        check_eq("coll_dstE", ifc.dstE, 4'h4);
        check_eq("coll_dstM", ifc.dstM, 4'h4);
        check_eq("coll_valE", ifc.valE, 64'h111);
        check_eq("coll_valM", ifc.valM, 64'h222);
        force dut.retired_r = 32'hFFFF_FFFF;
        #1;
        release dut.retired_r;
        m_ret = 32'hFFFF_FFFF;
        check_eq("wrap_preload", ifc.retired, 32'hFFFF_FFFF);
        drive(3'd1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b1);
        step();
        check_eq("wrap_retired", ifc.retired, 32'd0);

        // Randomized traffic
        halt_age = 0;
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [2:0] st;
            r = int'($urandom_range(0, 39));
            st = (r == 0) ? 3'd2 : (r == 1) ? 3'd3 : (r == 2) ? 3'd4 : 3'd1;
            drive(st, 4'($urandom), 4'($urandom), 4'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            halt_age = m_halted ? halt_age + 1 : 0;
            reset = (halt_age > 4) || ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
